// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write-port arbiter: ALU/LSU round-robin, starvation-protected SDU
module rf_wb_arbiter #(
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    input  logic        sdu_valid,
    output logic        sdu_ready,
    input  logic [4:0]  sdu_rd,
    input  logic [31:0] sdu_data,
    output logic        RegWrite,
    output logic [4:0]  rw,
    output logic [31:0] busW,
    output logic [1:0]  grant_id,
    output logic        sdu_forced
);

    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

    logic             rr_q, rr_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             regwrite_q;
    logic [4:0]       rw_q;
    logic [31:0]      busw_q;
    logic [1:0]       grant_id_q;
    logic             sdu_forced_q;

    logic             grant_alu, grant_lsu, grant_sdu, force_sdu;
    logic [4:0]       sel_rd;
    logic [31:0]      sel_data;

    always_comb begin
        grant_alu = 1'b0;
        grant_lsu = 1'b0;
        grant_sdu = 1'b0;
        rr_d      = rr_q;
        wait_d    = wait_q;
        force_sdu = sdu_valid && (wait_q == WAIT_MAX);

        // A starved SDU preempts both ALU and LSU and leaves their pointer alone.
        if (!rst) begin
            if (force_sdu) begin
                grant_sdu = 1'b1;
            end else if (alu_valid && lsu_valid) begin
                grant_alu = !rr_q;
                grant_lsu = rr_q;
            end else if (alu_valid) begin
                grant_alu = 1'b1;
            end else if (lsu_valid) begin
                grant_lsu = 1'b1;
            end else if (sdu_valid) begin
                grant_sdu = 1'b1;
            end
        end

        if (grant_alu) begin
            rr_d = 1'b1;
        end else if (grant_lsu) begin
            rr_d = 1'b0;
        end

        if (!sdu_valid || grant_sdu) begin
            wait_d = '0;
        end else if (wait_q != WAIT_MAX) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_comb begin
        sel_rd   = alu_rd;
        sel_data = alu_data;
        if (grant_lsu) begin
            sel_rd   = lsu_rd;
            sel_data = lsu_data;
        end else if (grant_sdu) begin
            sel_rd   = sdu_rd;
            sel_data = sdu_data;
        end
    end

    assign alu_ready = grant_alu;
    assign lsu_ready = grant_lsu;
    assign sdu_ready = grant_sdu;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q         <= 1'b0;
            wait_q       <= '0;
            regwrite_q   <= 1'b0;
            rw_q         <= 5'd0;
            busw_q       <= 32'd0;
            grant_id_q   <= 2'd3;
            sdu_forced_q <= 1'b0;
        end else begin
            rr_q   <= rr_d;
            wait_q <= wait_d;
            if (grant_alu || grant_lsu || grant_sdu) begin
                // x0 writes are accepted but never enabled, so x0 stays zero.
                regwrite_q   <= (sel_rd != 5'd0);
                rw_q         <= sel_rd;
                busw_q       <= sel_data;
                grant_id_q   <= grant_sdu ? 2'd2 : (grant_lsu ? 2'd1 : 2'd0);
                sdu_forced_q <= grant_sdu && force_sdu;
            end else begin
                regwrite_q   <= 1'b0;
                grant_id_q   <= 2'd3;
                sdu_forced_q <= 1'b0;
            end
        end
    end

    assign RegWrite   = regwrite_q;
    assign rw         = rw_q;
    assign busW       = busw_q;
    assign grant_id   = grant_id_q;
    assign sdu_forced = sdu_forced_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter against a behavioural model
module tb_rf_wb_arbiter;

    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, lsu_valid, sdu_valid;
    logic        alu_ready, lsu_ready, sdu_ready;
    logic [4:0]  alu_rd, lsu_rd, sdu_rd;
    logic [31:0] alu_data, lsu_data, sdu_data;
    logic        RegWrite;
    logic [4:0]  rw;
    logic [31:0] busW;
    logic [1:0]  grant_id;
    logic        sdu_forced;

    int errors = 0;
    int checks = 0;

    logic [31:0] rf [32];
    logic [31:0] rf_exp [32];

    int          m_pref;
    int          m_denied;
    logic        m_we;
    logic [4:0]  m_rw;
    logic [31:0] m_busw;
    int          m_gid;
    logic        m_forced;
    int          acc;

    rf_wb_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .sdu_valid(sdu_valid), .sdu_ready(sdu_ready), .sdu_rd(sdu_rd), .sdu_data(sdu_data),
        .RegWrite(RegWrite), .rw(rw), .busW(busW), .grant_id(grant_id), .sdu_forced(sdu_forced)
    );

    always #5 clk = ~clk;

    // Register file fed by the arbiter; a reset edge blocks the commit.
    always @(posedge clk) begin
        if (!rst && RegWrite && rw != 5'd0) rf[rw] <= busW;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pref   = 0;
        m_denied = 0;
        m_we     = 1'b0;
        m_rw     = 5'd0;
        m_busw   = 32'd0;
        m_gid    = 3;
        m_forced = 1'b0;
    endtask

    // One clock: check combinational readies and registered outputs, then advance the model.
    task automatic step();
        int   g;
        logic frc;
        int   idx;
        @(negedge clk);
        g   = 3;
        frc = 1'b0;
        if (!rst) begin
            if (sdu_valid && m_denied >= MAX_WAIT) begin
                g = 2; frc = 1'b1;
            end else if (alu_valid && lsu_valid) g = m_pref;
            else if (alu_valid) g = 0;
            else if (lsu_valid) g = 1;
            else if (sdu_valid) g = 2;
        end
        check_eq("alu_ready", alu_ready, g == 0);
        check_eq("lsu_ready", lsu_ready, g == 1);
        check_eq("sdu_ready", sdu_ready, g == 2);
        check_eq("RegWrite", RegWrite, m_we);
        check_eq("rw", rw, m_rw);
        check_eq("busW", busW, m_busw);
        check_eq("grant_id", grant_id, m_gid);
        check_eq("sdu_forced", sdu_forced, m_forced);
        idx = $urandom_range(0, 31);
        check_eq("regfile", rf[idx], rf_exp[idx]);

        if (!rst && m_we && m_rw != 5'd0) rf_exp[m_rw] = m_busw;
        if (rst) begin
            model_reset();
        end else begin
            if (g == 3) begin
                m_we = 1'b0; m_gid = 3; m_forced = 1'b0;
            end else begin
                m_rw     = (g == 0) ? alu_rd : (g == 1) ? lsu_rd : sdu_rd;
                m_busw   = (g == 0) ? alu_data : (g == 1) ? lsu_data : sdu_data;
                m_we     = (m_rw != 5'd0);
                m_gid    = g;
                m_forced = frc;
            end
            if (g == 0) m_pref = 1;
            if (g == 1) m_pref = 0;
            if (!sdu_valid || g == 2) m_denied = 0;
            else if (m_denied < MAX_WAIT) m_denied++;
        end
        acc = g;
        @(posedge clk);
        #1;
    endtask

    task automatic regen();
        if (acc == 0 || !alu_valid) begin
            alu_valid = $urandom_range(0, 1); alu_rd = $urandom_range(0, 31); alu_data = $urandom;
        end
        if (acc == 1 || !lsu_valid) begin
            lsu_valid = $urandom_range(0, 1); lsu_rd = $urandom_range(0, 31); lsu_data = $urandom;
        end
        if (acc == 2 || !sdu_valid) begin
            sdu_valid = ($urandom_range(0, 3) == 0); sdu_rd = $urandom_range(0, 31); sdu_data = $urandom;
        end
        rst = ($urandom_range(0, 49) == 0);
    endtask

    initial begin
        int found;
        int exp_seq [4];
        exp_seq = '{0, 1, 0, 1};
        for (int i = 0; i < 32; i++) begin
            rf[i] = 32'd0; rf_exp[i] = 32'd0;
        end
        acc = 3;
        model_reset();
        rst = 1'b1;
        alu_valid = 1'b1; lsu_valid = 1'b1; sdu_valid = 1'b1;
        alu_rd = 5'd1; lsu_rd = 5'd2; sdu_rd = 5'd3;
        alu_data = 32'h1; lsu_data = 32'h2; sdu_data = 32'h3;
        @(posedge clk); #1;
        step(); step();

        rst = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0; sdu_valid = 1'b0;
        repeat (3) step();

        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234_5678;
        step();
        alu_valid = 1'b0;
        step();
        check_eq("x5_commit", rf[5], 32'h1234_5678);

        rst = 1'b1; step(); rst = 1'b0;
        alu_valid = 1'b1; lsu_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alu_rd = 5'd10 + 5'(i); alu_data = $urandom;
            lsu_rd = 5'd20 + 5'(i); lsu_data = $urandom;
            step();
            check_eq("rr_seq", grant_id, exp_seq[i]);
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        step();

        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hFFFF_FFFF;
        step();
        lsu_valid = 1'b0;
        check_eq("x0_gid", grant_id, 2'd1);
        check_eq("x0_we", RegWrite, 1'b0);
        step();
        check_eq("x0_zero", rf[0], 32'd0);

        rst = 1'b1; step(); rst = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = $urandom;
        sdu_valid = 1'b1; sdu_rd = 5'd3; sdu_data = 32'hD0D0_0003;
        found = 0;
        for (int e = 1; e <= 12 && found == 0; e++) begin
            step();
            if (grant_id == 2'd2) found = e;
            if (acc == 0) alu_data = $urandom;
            if (acc == 2) sdu_valid = 1'b0;
        end
        check_eq("forced_edge", found, MAX_WAIT + 1);
        check_eq("forced_flag", sdu_forced, 1'b1);
        step();
        check_eq("alu_resume", grant_id, 2'd0);
        alu_valid = 1'b0;
        step(); step();

        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hAAAA_0007;
        step();
        lsu_data = 32'hBBBB_0007;
        rst = 1'b1;
        step();
        rst = 1'b0; lsu_valid = 1'b0;
        check_eq("rst_we", RegWrite, 1'b0);
        check_eq("rst_x7", rf[7], 32'd0);
        step();

        acc = 3;
        for (int i = 0; i < 400; i++) begin
            regen();
            step();
        end
        rst = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0; sdu_valid = 1'b0;
        step(); step();
        for (int i = 0; i < 32; i++) check_eq("rf_final", rf[i], rf_exp[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
